freq_meter_ctrl: RTL and testbench

//  Sequences a frequency measurement: opens a fixed gate window, counts rising edges of sig_in
//  in a 4-digit BCD decade cascade, and latches the result for the 7-segment decoder
//  (16-bit packed BCD in, digit0 = [3:0]). Sits between the raw input pin and the display path.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/bcd_digit_cnt.sv | 25 ++
 rtl/freq_meter_ctrl.sv | 138 +++++++++++++
 tb/tb_freq_meter_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter controller and its BCD decade counters.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    GATE,
    LATCH
  } state_t;

  localparam int         BCD_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One decade of the BCD edge counter; carry is combinational so a 4-digit chain advances in one clk.
module bcd_digit_cnt
  import freq_meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/freq_meter_ctrl.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clocks into 4 BCD digits.
// Optional macro RESULT_HOLD_EN adds a hold input that freezes the displayed result.
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        run,
`ifdef RESULT_HOLD_EN
  input  logic        hold,
`endif
  output logic [15:0] bcd_out,
  output logic        overflow,
  output logic        valid,
  output logic        busy
);

  state_t                  state, state_nxt;
  logic                    s1, s2, s3;
  logic                    edge_det;
  logic [CNT_W-1:0]        gate_cnt;
  logic                    gate_last;
  logic                    clr;
  logic                    gate_edge;
  logic                    all_nines;
  logic                    sticky_ovf;
  logic                    latch_en;
  logic [BCD_DIGITS-1:0]   inc;
  logic [BCD_DIGITS-1:0]   carry;
  logic [4*BCD_DIGITS-1:0] count;
  logic                    unused_carry;

  // s1/s2 resolve metastability; s3 delays s2 so a rising edge is seen exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det  = s2 & ~s3;
  assign gate_last = (gate_cnt == CNT_W'(GATE_CYCLES - 1));
  assign clr       = (state == CLEAR);
  assign gate_edge = (state == GATE) & edge_det;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = CLEAR;
      CLEAR:   state_nxt = GATE;
      GATE:    if (gate_last) state_nxt = LATCH;
      LATCH:   state_nxt = run ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (clr) begin
      gate_cnt <= '0;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt + CNT_W'(1);
    end
  end

  // At 9999 further edges are blocked from the chain so the count saturates instead of wrapping
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (count[4*i +: 4] != BCD_MAX) all_nines = 1'b0;
    end
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_first
      assign inc[g] = gate_edge & ~all_nines;
    end else begin : g_chain
      assign inc[g] = carry[g-1];
    end
    bcd_digit_cnt u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[g]),
      .digit (count[4*g +: 4]),
      .carry (carry[g])
    );
  end

  assign unused_carry = carry[BCD_DIGITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (clr) begin
      sticky_ovf <= 1'b0;
    end else if (gate_edge & all_nines) begin
      sticky_ovf <= 1'b1;
    end
  end

`ifdef RESULT_HOLD_EN
  assign latch_en = (state == LATCH) & ~hold;
`else
  assign latch_en = (state == LATCH);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out  <= 16'h0000;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= latch_en;
      if (latch_en) begin
        bcd_out  <= count;
        overflow <= sticky_ovf;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Randomized bench for freq_meter_ctrl: a timeline model predicts every output each cycle,
// plus literal checks on latency, period, zero input, run drop, async reset and saturation.
module tb_freq_meter_ctrl;

  localparam int GATE     = 1000;
  localparam int GATE_SAT = 30000;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sig_in = 1'b0;
  logic        run    = 1'b0;
  logic        hold   = 1'b0;
  logic [15:0] bcd_out;
  logic        overflow, valid, busy;

  logic        rst_b_n = 1'b0;
  logic        sig_b   = 1'b0;
  logic        run_b   = 1'b0;
  logic        hold_b  = 1'b0;
  logic [15:0] bcd_b;
  logic        ovf_b, valid_b, busy_b;
  bit          sat_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  int mode   = 0;
  int period = 10;
  int phase  = 0;

  logic [15:0] exp_bcd   = 16'h0000;
  logic        exp_ovf   = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_busy  = 1'b0;
  int          m_cyc = 0, m_k = 0, m_cnt = 0;
  bit          m_active = 1'b0, m_prev = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  freq_meter_ctrl #(.GATE_CYCLES(GATE), .CNT_W(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .run      (run),
`ifdef RESULT_HOLD_EN
    .hold     (hold),
`endif
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .valid    (valid),
    .busy     (busy)
  );

  freq_meter_ctrl #(.GATE_CYCLES(GATE_SAT), .CNT_W(15)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_b_n),
    .sig_in   (sig_b),
    .run      (run_b),
`ifdef RESULT_HOLD_EN
    .hold     (hold_b),
`endif
    .bcd_out  (bcd_b),
    .overflow (ovf_b),
    .valid    (valid_b),
    .busy     (busy_b)
  );

  function automatic logic [15:0] to_bcd(input int c);
    int v;
    v = (c > 9999) ? 9999 : c;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, tb_cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input int m, input int p);
    run    = r;
    mode   = m;
    period = p;
  endtask

  task automatic waitValid(input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        at = tb_cyc;
        break;
      end
    end
  endtask

  // Input waveform generator: 0 = held low, 1 = square wave of 'period' clk, 2 = random bits
  initial forever begin
    @(negedge clk);
    case (mode)
      1: begin
        sig_in = (phase < period / 2);
        phase  = (phase + 1) % period;
      end
      2:       sig_in = 1'($urandom_range(0, 1));
      default: sig_in = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    sig_b = ~sig_b;
  end

  // A measurement started at edge k sees input samples k-1..k+GATE-1 (two-flop sync delay),
  // and its result appears GATE+2 edges later; run at that edge decides whether another starts.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active  = 1'b0;
      m_cnt     = 0;
      m_prev    = 1'b0;
      exp_bcd   = 16'h0000;
      exp_ovf   = 1'b0;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      m_cyc++;
      exp_valid = 1'b0;
      if (m_active && m_cyc == m_k + GATE + 2) begin
        if (!hold) begin
          exp_valid = 1'b1;
          exp_bcd   = to_bcd(m_cnt);
          exp_ovf   = (m_cnt > 9999);
        end
        m_active = 1'b0;
      end
      if (!m_active && run) begin
        m_active = 1'b1;
        m_k      = m_cyc;
        m_cnt    = 0;
      end
      if (m_active && (m_cyc - m_k) < GATE && sig_in && !m_prev) m_cnt++;
      m_prev   = sig_in;
      exp_busy = m_active;
    end
  end

  initial forever begin
    @(negedge clk);
    checkOutput("cycle_model", 32'({valid, busy, overflow, bcd_out}),
                32'({exp_valid, exp_busy, exp_ovf, exp_bcd}));
  end

  initial begin
    bit ok;
    rst_b_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_b_n = 1'b1;
    run_b   = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < GATE_SAT + 100; i++) begin
      @(negedge clk);
      if (valid_b) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("sat_valid_seen", 32'(ok), 32'd1);
    checkOutput("sat_bcd", 32'(bcd_b), 32'h9999);
    checkOutput("sat_overflow", 32'(ovf_b), 32'd1);
    run_b    = 1'b0;
    sat_done = 1'b1;
  end

  initial begin
    int r0, v1, v2, v3, n_valid, n_busy;
    bit ok;

    repeat (3) @(negedge clk);
    checkOutput("reset_state", 32'({valid, busy, overflow, bcd_out}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] square wave period 10, continuous run");
    r0 = tb_cyc;
    applyStimulus(1'b1, 1, 10);
    waitValid(GATE + 10, v1, ok);
    checkOutput("p10_valid_seen", 32'(ok), 32'd1);
    checkOutput("p10_latency", 32'(v1 - r0), 32'(GATE + 3));
    checkOutput("p10_value", 32'(bcd_out >= 16'h0099 && bcd_out <= 16'h0101), 32'd1);
    checkOutput("p10_overflow", 32'(overflow), 32'd0);
    waitValid(GATE + 10, v2, ok);
    checkOutput("p10_period_1", 32'(v2 - v1), 32'(GATE + 2));
    waitValid(GATE + 10, v3, ok);
    checkOutput("p10_period_2", 32'(v3 - v2), 32'(GATE + 2));
    checkOutput("p10_value_2", 32'(bcd_out), 32'h0100);

    $display("[TB] input held low");
    applyStimulus(1'b1, 0, 10);
    waitValid(GATE + 10, v1, ok);
    waitValid(GATE + 10, v2, ok);
    checkOutput("low_valid_seen", 32'(ok), 32'd1);
    checkOutput("low_bcd", 32'(bcd_out), 32'h0000);
    checkOutput("low_overflow", 32'(overflow), 32'd0);

    $display("[TB] randomized input patterns");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, $urandom_range(1, 2), $urandom_range(2, 40));
      waitValid(GATE + 10, v1, ok);
      checkOutput("rand_valid_seen", 32'(ok), 32'd1);
    end

    $display("[TB] run dropped mid-gate");
    applyStimulus(1'b1, 1, $urandom_range(3, 30));
    waitValid(GATE + 10, v1, ok);
    repeat (300) @(negedge clk);
    applyStimulus(1'b0, 1, period);
    waitValid(GATE + 10, v2, ok);
    checkOutput("drop_final_valid", 32'(ok), 32'd1);
    checkOutput("drop_final_timing", 32'(v2 - v1), 32'(GATE + 2));
    checkOutput("drop_busy_low", 32'(busy), 32'd0);
    n_valid = 0;
    repeat (2000) begin
      @(negedge clk);
      if (valid) n_valid++;
    end
    checkOutput("drop_no_more_valid", 32'(n_valid), 32'd0);

    $display("[TB] async reset during gate");
    applyStimulus(1'b1, 1, 6);
    waitValid(GATE + 10, v1, ok);
    repeat (400) @(negedge clk);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    checkOutput("async_reset_clears", 32'({valid, busy, overflow, bcd_out}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    n_valid = 0;
    n_busy  = 0;
    repeat (GATE + 100) begin
      @(negedge clk);
      if (valid) n_valid++;
      if (busy) n_busy++;
    end
    checkOutput("post_reset_no_valid", 32'(n_valid), 32'd0);
    checkOutput("post_reset_idle", 32'(n_busy), 32'd0);

`ifdef RESULT_HOLD_EN
    $display("[TB] result hold");
    applyStimulus(1'b1, 1, 10);
    waitValid(GATE + 10, v1, ok);
    waitValid(GATE + 10, v2, ok);
    hold = 1'b1;
    applyStimulus(1'b1, 1, 4);
    n_valid = 0;
    repeat (GATE + 10) begin
      @(negedge clk);
      if (valid) n_valid++;
    end
    checkOutput("hold_no_valid", 32'(n_valid), 32'd0);
    checkOutput("hold_keeps_bcd", 32'(bcd_out), 32'h0100);
    hold = 1'b0;
    waitValid(GATE + 10, v3, ok);
    checkOutput("hold_release_valid", 32'(ok), 32'd1);
    checkOutput("hold_release_value", 32'(bcd_out >= 16'h0249 && bcd_out <= 16'h0251), 32'd1);
`endif

    applyStimulus(1'b0, 0, 10);
    for (int i = 0; i < 40000 && !sat_done; i++) @(negedge clk);
    checkOutput("sat_finished", 32'(sat_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
